addsub_16bit_serial: RTL and testbench
======================================

# addsub_16bit_serial

Nibble-serial 16-bit signed saturating add/subtract unit for the ALU's ADD/SUB path. It time-multiplexes a single `add_4bit` instance over four cycles and registers the inter-nibble carry. It applies two's-complement saturation to the final result. It sits between the ALU operand muxes (upstream) and the ALU result/flag mux (downstream), and signals completion with a start/busy/done handshake.

## Interface
Parameters:
- `WIDTH`, 16: operand and result width. Must be a multiple of 4.
- `NIBBLES`, `WIDTH/4`: number of serial add steps.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request; sampled only when the unit is idle or in DONE.
- `A`  in  WIDTH: operand A, signed.
- `B`  in  WIDTH: operand B, signed.
- `sub`  in  1: 0 computes A+B; 1 computes A−B.
- `busy`  out  1: high while a request is in progress.
- `done`  out  1: one-cycle pulse; Sum/Ovfl are valid.
- `Sum`  out  WIDTH: saturated result, held until the next completion.
- `Ovfl`  out  1: signed overflow occurred (saturation applied), held with Sum.

## Operation
- FSM states:
  - IDLE: start=1 latches A, B (or ~B if sub), sub, and sets nibble index 0 → RUN.
  - RUN: each cycle adds nibble[idx] of the latched operands with the carry register. The sum nibble is written into the partial result and Cout into the carry register. After idx=NIBBLES−1 → DONE.
  - DONE: done=1 for one cycle. start=1 here is accepted exactly as in IDLE (back-to-back); otherwise → IDLE.
- Carry-in for nibble 0 = latched sub. For later nibbles it is the registered Cout of the previous nibble.
- Operands are latched at acceptance. Changes to A/B/sub while busy have no effect.
- Overflow is detected on the final step: sign(A) == sign(B_eff) and sign(raw result) ≠ sign(A), where B_eff is B, or ~B when sub=1.
- Saturation:
  - Positive overflow → 0x7FFF.
  - Negative overflow → 0x8000.
  - Otherwise Sum = raw result.
- Final carry-out is discarded; it does not appear on any port.
- start while in RUN is ignored; there is no queueing.
- Reset values: busy=0, done=0, Sum=0, Ovfl=0, state=IDLE, carry register=0.
- rst mid-RUN aborts immediately. The partial result is discarded, and Sum/Ovfl do not change from their pre-reset values other than the reset clear to 0.

## Timing
- start accepted at edge N → busy=1 from edge N through edge N+NIBBLES (exclusive of the DONE cycle).
- Nibbles 0..3 are processed at edges N+1..N+4.
- Sum/Ovfl update and done=1 at edge N+4, i.e. done is visible in the cycle after the 4th nibble edge.
- busy=0 during the DONE cycle.
- Throughput: one result per NIBBLES+1 cycles when idle between requests. One result per NIBBLES cycles when start is held high through DONE.
- rst has priority over start and over every FSM transition.

## Structure
- Shared package `alu_pkg`:
  - FSM state enum (IDLE, RUN, DONE).
  - WIDTH/NIBBLES defaults.
  - Saturation constants SAT_POS = 16'h7FFF and SAT_NEG = 16'h8000.
- Exactly one sub-module instance: `add_4bit`, driven by nibble muxes on the latched operands.
- Nibble index counter: 2 bits for WIDTH=16.

## Test plan
- 0x1234 + 0x1111, sub=0 → Sum=0x2345, Ovfl=0, done pulse exactly at N+4, busy high N..N+3.
- 0x0FFF + 0x0001 → Sum=0x1000, Ovfl=0. Checks carry propagation through three nibble boundaries.
- 0x7FFF + 0x0001 → Sum=0x7FFF, Ovfl=1. Also 0x8000 − 0x0001 (sub=1) → Sum=0x8000, Ovfl=1.
- 0x0005 − 0x0007 → Sum=0xFFFE, Ovfl=0. Then 0x0007 − 0x0007 → 0x0000, Ovfl=0.
- start pulsed at N+2 with different operands and A/B toggled mid-RUN → ignored; result is still from the operands latched at N. Back-to-back start held through DONE → second done at N+8.
- rst asserted at N+2 → busy=0, done=0, Sum=0, Ovfl=0 at the next edge, no done pulse. A fresh request afterwards completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, default geometry and
// two's-complement saturation limits for the 16-bit datapath.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEF   = 16;
  localparam int unsigned NIBBLES_DEF = WIDTH_DEF / 4;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

endpackage

// File: rtl/add_4bit.sv
// 4-bit ripple adder with carry in/out; the single arithmetic element
// that the serial unit reuses for every nibble.
module add_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/addsub_16bit_serial.sv
// Nibble-serial signed saturating add/subtract: one add_4bit shared over
// NIBBLES cycles, registered inter-nibble carry, start/busy/done handshake.
module addsub_16bit_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Ovfl
);

  localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q, b_q, part_q, sum_q;
  logic              ovfl_q;

  logic [WIDTH-1:0]  b_in, raw;
  logic [3:0]        nib_a, nib_b, nib_s;
  logic              nib_cin, nib_cout;
  logic              start_run, last, ovf;
  logic [WIDTH-1:0]  sat;

  assign b_in = sub ? ~B : B;

  add_4bit u_add (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (nib_cin),
    .s    (nib_s),
    .cout (nib_cout)
  );

  // A start held through DONE feeds nibble 0 straight from the ports so the
  // accepting edge already does useful work, giving one result per NIBBLES.
  always_comb begin
    start_run = (state_q == DONE) && start;
    nib_a     = a_q[4*idx_q +: 4];
    nib_b     = b_q[4*idx_q +: 4];
    nib_cin   = carry_q;
    if (start_run) begin
      nib_a   = A[3:0];
      nib_b   = b_in[3:0];
      nib_cin = sub;
    end
    raw                = part_q;
    raw[4*idx_q +: 4]  = nib_s;
    last               = (state_q == RUN) && (idx_q == LAST_IDX);
    ovf                = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (raw[WIDTH-1] != a_q[WIDTH-1]);
    sat                = raw;
    if (ovf) sat = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      ovfl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= b_in;
            idx_q   <= '0;
            carry_q <= sub;
          end
        end
        RUN: begin
          part_q[4*idx_q +: 4] <= nib_s;
          carry_q              <= nib_cout;
          idx_q                <= idx_q + 1'b1;
          if (last) begin
            sum_q  <= sat;
            ovfl_q <= ovf;
          end
        end
        DONE: begin
          if (start) begin
            a_q         <= A;
            b_q         <= b_in;
            part_q[3:0] <= nib_s;
            carry_q     <= nib_cout;
            idx_q       <= IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Sum  = sum_q;
  assign Ovfl = ovfl_q;

endmodule

// File: tb/tb_addsub_16bit_serial.sv
// Directed self-checking bench for addsub_16bit_serial: handshake timing,
// carry ripple, saturation, mid-run interference, back-to-back and reset.
module tb_addsub_16bit_serial;

  logic        clk = 1'b0;
  logic        rst, start, sub;
  logic [15:0] A, B;
  logic        busy, done, Ovfl;
  logic [15:0] Sum;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  addsub_16bit_serial #(.WIDTH(16), .NIBBLES(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .sub  (sub),
    .busy (busy),
    .done (done),
    .Sum  (Sum),
    .Ovfl (Ovfl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Full request with idle return; checks busy/done timing around edge N.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] exp_sum, input logic exp_ovf);
    A = a; B = b; sub = s; start = 1'b1;
    edge1();                       // edge N
    start = 1'b0;
    check("busy_n", busy, 1);
    check("done_n", done, 0);
    for (int i = 1; i < 4; i++) begin
      edge1();
      check("busy_run", busy, 1);
      check("done_run", done, 0);
    end
    edge1();                       // edge N+4
    check("done_pulse", done, 1);
    check("busy_done", busy, 0);
    check("sum", Sum, exp_sum);
    check("ovfl", Ovfl, exp_ovf);
    edge1();
    check("done_drop", done, 0);
    check("sum_hold", Sum, exp_sum);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    edge1(); edge1();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", Sum, 0);
    check("rst_ovfl", Ovfl, 0);
    rst = 1'b0;
    edge1();

    run_op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
    run_op(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1);
    run_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
    run_op(16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1);
    run_op(16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);

    // Start and operand changes during RUN are ignored.
    A = 16'h0100; B = 16'h0022; sub = 1'b0; start = 1'b1;
    edge1();                       // N
    start = 1'b0;
    edge1();                       // N+1
    A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1; start = 1'b1;
    edge1();                       // N+2
    start = 1'b0; A = 16'h5555;
    edge1(); edge1();              // N+4
    check("ign_done", done, 1);
    check("ign_sum", Sum, 16'h0122);
    check("ign_ovfl", Ovfl, 0);
    edge1();
    check("ign_no_second", done, 0);
    check("ign_idle", busy, 0);

    // Back-to-back: start held through DONE.
    A = 16'h0001; B = 16'h0002; sub = 1'b0; start = 1'b1;
    edge1();                       // N
    for (int i = 1; i < 4; i++) edge1();
    edge1();                       // N+4
    check("b2b_done1", done, 1);
    check("b2b_sum1", Sum, 16'h0003);
    A = 16'h0010; B = 16'h0003; sub = 1'b1;
    edge1();                       // N+5
    check("b2b_busy", busy, 1);
    check("b2b_done_low", done, 0);
    start = 1'b0;
    edge1(); edge1();              // N+7
    check("b2b_not_yet", done, 0);
    edge1();                       // N+8
    check("b2b_done2", done, 1);
    check("b2b_sum2", Sum, 16'h000D);
    check("b2b_ovfl2", Ovfl, 0);
    edge1();

    // Load a nonzero held result, then abort a run with reset at N+2.
    run_op(16'h7000, 16'h1000, 1'b0, 16'h7FFF, 1'b1);
    A = 16'h0003; B = 16'h0004; sub = 1'b0; start = 1'b1;
    edge1();                       // N
    start = 1'b0;
    edge1();                       // N+1
    rst = 1'b1;
    edge1();                       // N+2
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", Sum, 0);
    check("abort_ovfl", Ovfl, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge1();
      check("abort_no_done", done, 0);
    end
    run_op(16'h4321, 16'h1234, 1'b1, 16'h30ED, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
